uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver reports complete, stores it in a first-word-fall-through FIFO, and presents it to the consumer (counter/command logic) over a valid/ready handshake. Overrun is detected and latched as a sticky error.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `WIDTH`, 8: data width; must match the receiver byte width.

- `clk`  in  1  system clock (100 MHz domain shared with the receiver).
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock domain.
- `rx_data`  in  WIDTH  receiver byte; valid only in cycles where `rx_done` is high.
- `rx_done`  in  1  receiver byte-complete strobe; nominally a 1-cycle pulse.
- `out_data`  out  WIDTH  head-of-FIFO byte; valid when `out_valid` is high.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head byte when high together with `out_valid`.
- `count`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky overrun flag.
- `ovf_clr`  in  1  synchronous clear for `overflow`.

## Operation
- Push strobe: `push = rx_done & ~rx_done_q`, where `rx_done_q` is `rx_done` registered. A `rx_done` held high for several cycles therefore yields exactly one push. `rx_data` is sampled in the push cycle itself, because the receiver clears its data register on the following cycle.
- Pop: `pop = out_valid & out_ready`.
- Pointers: `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide. The low bits index storage and the MSB is the wrap bit, so both pointers wrap naturally modulo 2·DEPTH.
  - `empty` when the pointers are equal.
  - `full` when the low bits are equal and the MSBs differ.
  - `count = wr_ptr - rd_ptr`, computed modulo 2·DEPTH.
- `out_data = mem[rd_ptr low bits]`, a combinational read from the register array (first-word fall-through).
- Boundary cases:
  - Push while not full: write at `wr_ptr`, then `wr_ptr++`.
  - Push while full, no pop: byte dropped, no pointer change, `overflow` set.
  - Push while full, with pop: both proceed; `count` stays at DEPTH and no overflow is raised.
  - Push while empty with `out_ready` high: only the push occurs, because `out_valid` is low that cycle.
  - Pop while empty: impossible by construction; pointers never move.
  - `ovf_clr` and a new overrun in the same cycle: set wins, so `overflow` stays 1.
- Reset (asynchronous, at any time, including mid-burst):
  - `wr_ptr = rd_ptr = 0`, `rx_done_q = 0`, `overflow = 0`.
  - Storage contents are not reset and are don't-care.
  - Outputs during and after reset: `out_valid=0`, `empty=1`, `full=0`, `count=0`, `overflow=0`. `out_data` is undefined while `empty`.
  - A `rx_done` that is already high when reset deasserts is treated as a rising edge and pushed on the first clock.

## Timing
- Push at edge N → `out_valid=1` and `count` incremented immediately after edge N, so the byte is consumable in cycle N+1. Latency from `rx_done` rising to `out_valid` is 1 clk.
- Pop at edge N → the next byte (or `empty`) appears after edge N; zero-bubble back-to-back pops are allowed.
- Sustained throughput: one push and one pop per clock.
- `overflow` rises the cycle after the dropped push.
- `full`, `empty` and `count` are all derived from registered pointers, so they are glitch-free relative to `clk`.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W = 8` and `FIFO_DEPTH_DEFAULT = 16`. The baud/receiver parameters also live there.
- Sub-module `fifo_mem`: a WIDTH × DEPTH register array with one synchronous write port and one asynchronous read port, and no reset.
- Pointer, flag, edge-detect and overflow logic stay in `uart_rx_fifo`.

## Test plan
- Single byte: after reset, pulse `rx_done` with `rx_data=8'hA5` and `out_ready=0` → next cycle `out_valid=1`, `out_data=8'hA5`, `count=1`. Raise `out_ready` for 1 clk → `empty=1`, `count=0`.
- Fill and order: push 0x00..0x0F with `out_ready=0` → `full=1`, `count=16`, `overflow=0`. Drain → bytes appear in order 0x00..0x0F, then `empty=1`.
- Overrun: with the FIFO full, push 0x55 → byte dropped, `overflow=1`, `count=16`. Assert `ovf_clr` together with another push of 0x66 → `overflow` stays 1. Assert `ovf_clr` alone → `overflow=0`.
- Full with simultaneous push/pop: FIFO full, `out_ready=1`, push 0x77 → `count` stays 16, no overflow, 0x77 is read last after 15 further pops.
- Held strobe and wrap: hold `rx_done` high for 5 clks with `rx_data=8'h3C` → exactly one entry. Then run 40 push/pop pairs with incrementing data → pointers wrap and the data is intact.
- Reset mid-operation: assert `rst_n=0` with 7 entries stored → `count=0`, `empty=1`, `out_valid=0`, `overflow=0`, all asynchronously without a clock edge. After release, a push of 0x11 reads back 0x11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART parameters for the receive path and the receive buffer.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

  localparam int unsigned CLK_FREQ_HZ   = 100_000_000;
  localparam int unsigned BAUD_RATE     = 115_200;
  localparam int unsigned CLKS_PER_BIT  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned OVERSAMPLE    = 16;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the receive FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: edge-detected push, FWFT pop,
// sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = UART_DATA_W,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rx_data_i,
  input  logic             rx_done_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rx_done_q;
  logic          overflow_q, overflow_d;
  logic          push, pop, wr_en;
  logic          empty, full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign push  = rx_done_i & ~rx_done_q;
  assign pop   = ~empty & out_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_done_q  <= rx_done_i;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (rx_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (out_data_o)
  );

  assign out_valid_o = ~empty;
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .DEPTH (16),
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data_i   (rx_data),
    .rx_done_i   (rx_done),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (overflow),
    .ovf_clr_i   (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe for one cycle, then a gap cycle so the next strobe is a fresh edge.
  task automatic push_byte(input logic [7:0] d);
    rx_done = 1'b1;
    rx_data = d;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check_eq(tag, out_data, d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;

    rst_n     = 1'b0;
    rx_data   = '0;
    rx_done   = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #12;
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte, 1-cycle latency
    rx_done = 1'b1;
    rx_data = 8'hA5;
    tick();
    rx_done = 1'b0;
    check_eq("single_valid", out_valid, 1);
    check_eq("single_data", out_data, 8'hA5);
    check_eq("single_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("single_empty", empty, 1);
    check_eq("single_count0", count, 0);

    // Fill
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check_eq("fill_full", full, 1);
    check_eq("fill_count", count, 16);
    check_eq("fill_ovf", overflow, 0);

    // Overrun, clear-vs-set priority, clear alone
    push_byte(8'h55);
    check_eq("ovr_ovf", overflow, 1);
    check_eq("ovr_count", count, 16);
    rx_done = 1'b1;
    rx_data = 8'h66;
    ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    check_eq("ovr_setwins", overflow, 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovr_clr", overflow, 0);
    check_eq("ovr_count2", count, 16);

    // Full with simultaneous push and pop
    check_eq("pp_head", out_data, 8'h00);
    rx_done   = 1'b1;
    rx_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    rx_done   = 1'b0;
    out_ready = 1'b0;
    check_eq("pp_count", count, 16);
    check_eq("pp_ovf", overflow, 0);
    tick();
    for (int i = 1; i < 16; i++) pop_expect($sformatf("drain_%0d", i), 8'(i));
    pop_expect("drain_77", 8'h77);
    check_eq("drain_empty", empty, 1);
    check_eq("drain_valid", out_valid, 0);

    // Held strobe gives exactly one entry
    rx_done = 1'b1;
    rx_data = 8'h3C;
    repeat (5) tick();
    rx_done = 1'b0;
    tick();
    check_eq("held_count", count, 1);
    check_eq("held_data", out_data, 8'h3C);

    // 40 push/pop pairs with one entry resident; pointers wrap past 2*DEPTH
    q.push_back(8'h3C);
    for (int k = 0; k < 40; k++) begin
      d = 8'(8'h80 + k);
      check_eq($sformatf("wrap_head_%0d", k), out_data, q.pop_front());
      q.push_back(d);
      rx_done   = 1'b1;
      rx_data   = d;
      out_ready = 1'b1;
      tick();
      rx_done   = 1'b0;
      out_ready = 1'b0;
      tick();
      check_eq($sformatf("wrap_count_%0d", k), count, 1);
    end
    pop_expect("wrap_last", q.pop_front());
    check_eq("wrap_empty", empty, 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 7; i++) push_byte(8'(8'hE0 + i));
    check_eq("mid_count7", count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    #3;
    rst_n = 1'b1;
    push_byte(8'h11);
    check_eq("post_rst_count", count, 1);
    check_eq("post_rst_data", out_data, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
